// File: rtl/isa_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : isa_pkg                                                |
// | Brief   : Shared word type, arbiter state encoding and the       |
// |           latched memory-request record.                         |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package isa_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

  // Request captured at grant time; held stable for the whole access
  typedef struct packed {
    word_t addr;
    word_t store;
    logic  wen;
  } mem_req_t;

endpackage : isa_pkg
`default_nettype wire

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : imem_dmem_arbiter                                      |
// | Brief   : Serialises fetch and load/store traffic onto a single  |
// |           memory port. Data wins arbitration, but a streak       |
// |           limiter hands the port to a waiting fetch after        |
// |           MAX_D_STREAK consecutive data grants. A redirect       |
// |           (iabort) suppresses the response of an in-flight fetch.|
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module imem_dmem_arbiter
  import isa_pkg::*;
#(
  parameter int WORD_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int STREAK_W     = 3
) (
  input  logic              CLK,
  input  logic              rst,
  // fetch side
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  input  logic              iabort,
  output logic              imem_hit,
  output logic [WORD_W-1:0] imemload,
  // load/store side
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [WORD_W-1:0] dmemaddr,
  input  logic [WORD_W-1:0] dmemstore,
  output logic              dmem_hit,
  output logic [WORD_W-1:0] dmemload,
  // memory side
  output logic              ram_REN,
  output logic              ram_WEN,
  output logic [WORD_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_store,
  input  logic [WORD_W-1:0] ram_load,
  input  logic              ram_ready
);

  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_D_STREAK);

  arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                drop_q, drop_d;
  mem_req_t            req_q, req_d;

  logic                fetch_req;
  logic                data_req;

  // A fetch raised together with a redirect is stale and must not win
  assign fetch_req = imemREN & ~iabort;
  assign data_req  = dmemREN | dmemWEN;

  // State, streak, drop flag and latched request registers
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      drop_q   <= 1'b0;
      req_q    <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      drop_q   <= drop_d;
      req_q    <= req_d;
    end
  end

  // Next-state arbitration and memory/response outputs
  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    drop_d    = 1'b0;
    req_d     = req_q;
    ram_REN   = 1'b0;
    ram_WEN   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    imem_hit  = 1'b0;
    imemload  = '0;
    dmem_hit  = 1'b0;
    dmemload  = '0;

    case (state_q)
      IDLE: begin
        if (data_req && (!fetch_req || (streak_q < MAX_STREAK))) begin
          state_d     = DBUSY;
          req_d.addr  = dmemaddr;
          req_d.store = dmemstore;
          req_d.wen   = dmemWEN;
          // Only a data grant that makes a fetch wait lengthens the streak
          if (imemREN && (streak_q != MAX_STREAK)) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (fetch_req) begin
          state_d     = IBUSY;
          req_d.addr  = imemaddr;
          req_d.store = '0;
          req_d.wen   = 1'b0;
          streak_d    = '0;
        end
        if (!imemREN) begin
          streak_d = '0;
        end
      end

      IBUSY: begin
        ram_REN  = 1'b1;
        ram_addr = req_q.addr;
        // Remember a redirect seen at any point of the access
        drop_d   = drop_q | iabort;
        if (ram_ready) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (!rst && !(drop_q | iabort)) begin
            imem_hit = 1'b1;
            imemload = ram_load;
          end
        end
      end

      DBUSY: begin
        ram_addr = req_q.addr;
        if (req_q.wen) begin
          ram_WEN   = 1'b1;
          ram_store = req_q.store;
        end else begin
          ram_REN = 1'b1;
        end
        if (ram_ready) begin
          state_d = IDLE;
          if (!rst) begin
            dmem_hit = 1'b1;
            if (!req_q.wen) begin
              dmemload = ram_load;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule : imem_dmem_arbiter
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_imem_dmem_arbiter                                   |
// | Brief   : Directed self-checking bench for imem_dmem_arbiter.    |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_imem_dmem_arbiter;
  import isa_pkg::*;

  logic        CLK = 1'b0;
  logic        rst;
  logic        imemREN, iabort, imem_hit;
  logic [31:0] imemaddr, imemload;
  logic        dmemREN, dmemWEN, dmem_hit;
  logic [31:0] dmemaddr, dmemstore, dmemload;
  logic        ram_REN, ram_WEN, ram_ready;
  logic [31:0] ram_addr, ram_store, ram_load;

  int n_checks = 0;
  int n_errors = 0;
  int ren_cnt;

  imem_dmem_arbiter #(
    .WORD_W      (32),
    .MAX_D_STREAK(4),
    .STREAK_W    (3)
  ) dut (
    .CLK      (CLK),
    .rst      (rst),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .iabort   (iabort),
    .imem_hit (imem_hit),
    .imemload (imemload),
    .dmemREN  (dmemREN),
    .dmemWEN  (dmemWEN),
    .dmemaddr (dmemaddr),
    .dmemstore(dmemstore),
    .dmem_hit (dmem_hit),
    .dmemload (dmemload),
    .ram_REN  (ram_REN),
    .ram_WEN  (ram_WEN),
    .ram_addr (ram_addr),
    .ram_store(ram_store),
    .ram_load (ram_load),
    .ram_ready(ram_ready)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs
  // sampled inside the low-risk window that follows.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; imemREN = 0; imemaddr = 0; iabort = 0;
    dmemREN = 0; dmemWEN = 0; dmemaddr = 0; dmemstore = 0;
    ram_load = 0; ram_ready = 0;
    cyc(); cyc();
    rst = 1'b0; settle();

    // ---- reset state
    check("rst_state",  32'(dut.state_q), 32'(IDLE));
    check("rst_streak", 32'(dut.streak_q), 32'd0);
    check("rst_drop",   32'(dut.drop_q), 32'd0);
    check("rst_ren",    32'(ram_REN), 32'd0);
    check("rst_wen",    32'(ram_WEN), 32'd0);
    check("rst_addr",   ram_addr, 32'd0);
    check("rst_ihit",   32'(imem_hit), 32'd0);
    check("rst_dhit",   32'(dmem_hit), 32'd0);

    // ---- fetch-only: ready on third access cycle
    imemREN = 1; imemaddr = 32'h100; settle();
    check("f_idle_ren", 32'(ram_REN), 32'd0);
    ren_cnt = 0;
    cyc();
    ren_cnt += int'(ram_REN);
    check("f_c1_hit", 32'(imem_hit), 32'd0);
    cyc();
    ren_cnt += int'(ram_REN);
    check("f_c2_hit", 32'(imem_hit), 32'd0);
    cyc();
    ram_ready = 1; ram_load = 32'hDEADBEEF; settle();
    ren_cnt += int'(ram_REN);
    check("f_addr", ram_addr, 32'h100);
    check("f_ihit", 32'(imem_hit), 32'd1);
    check("f_load", imemload, 32'hDEADBEEF);
    check("f_dhit", 32'(dmem_hit), 32'd0);
    cyc();
    imemREN = 0; ram_ready = 0; settle();
    check("f_ren_cycles", 32'(ren_cnt), 32'd3);
    check("f_done_ren", 32'(ram_REN), 32'd0);
    check("f_done_ihit", 32'(imem_hit), 32'd0);

    // ---- write priority with requester changing mid-access
    dmemREN = 1; dmemWEN = 1; dmemaddr = 32'h40; dmemstore = 32'h1234;
    cyc();
    dmemaddr = 32'h44; dmemstore = 32'hFFFF; settle();
    check("w_wen",   32'(ram_WEN), 32'd1);
    check("w_ren",   32'(ram_REN), 32'd0);
    check("w_store", ram_store, 32'h1234);
    check("w_addr",  ram_addr, 32'h40);
    check("w_dhit0", 32'(dmem_hit), 32'd0);
    cyc();
    ram_ready = 1; ram_load = 32'h5555AAAA; settle();
    check("w_dhit", 32'(dmem_hit), 32'd1);
    check("w_ihit", 32'(imem_hit), 32'd0);
    cyc();
    dmemREN = 0; dmemWEN = 0; ram_ready = 0; settle();
    check("w_idle", 32'(dut.state_q), 32'(IDLE));
    check("w_dhit_after", 32'(dmem_hit), 32'd0);

    // ---- simultaneous requests: D,D,D,D,I repeating
    imemREN = 1; imemaddr = 32'h300; dmemREN = 1; dmemaddr = 32'h80;
    ram_ready = 1; ram_load = 32'h0BADF00D;
    for (int k = 0; k < 10; k++) begin
      logic exp_d;
      exp_d = ((k % 5) != 4);
      cyc();
      check($sformatf("s%0d_dhit", k), 32'(dmem_hit), 32'(exp_d));
      check($sformatf("s%0d_ihit", k), 32'(imem_hit), 32'(!exp_d));
      check($sformatf("s%0d_addr", k), ram_addr, exp_d ? 32'h80 : 32'h300);
      cyc();
    end
    imemREN = 0; dmemREN = 0; ram_ready = 0; settle();
    check("s_streak_end", 32'(dut.streak_q), 32'd0);

    // ---- iabort with a fresh fetch in IDLE blocks the grant
    imemREN = 1; iabort = 1; imemaddr = 32'h150;
    cyc();
    check("ab_idle_nogrant", 32'(dut.state_q), 32'(IDLE));
    imemREN = 0; iabort = 0;

    // ---- abort during IBUSY, plus address stability
    imemREN = 1; imemaddr = 32'h180;
    cyc();
    iabort = 1; imemaddr = 32'h200; settle();
    check("ab_ren", 32'(ram_REN), 32'd1);
    check("ab_ihit0", 32'(imem_hit), 32'd0);
    cyc();
    iabort = 0; settle();
    check("ab_addr_stable", ram_addr, 32'h180);
    check("ab_drop", 32'(dut.drop_q), 32'd1);
    cyc();
    ram_ready = 1; ram_load = 32'h11111111; settle();
    check("ab_ihit_supp", 32'(imem_hit), 32'd0);
    check("ab_dhit", 32'(dmem_hit), 32'd0);
    cyc();
    ram_ready = 0; settle();
    check("ab_idle", 32'(dut.state_q), 32'(IDLE));
    check("ab_drop_clr", 32'(dut.drop_q), 32'd0);
    cyc();
    ram_ready = 1; ram_load = 32'hCAFEF00D; settle();
    check("ab_next_addr", ram_addr, 32'h200);
    check("ab_next_hit", 32'(imem_hit), 32'd1);
    check("ab_next_load", imemload, 32'hCAFEF00D);
    cyc();
    imemREN = 0; ram_ready = 0; settle();

    // ---- reset during DBUSY
    imemREN = 1; imemaddr = 32'h400; dmemREN = 1; dmemaddr = 32'h90;
    cyc();
    check("r_dbusy", 32'(dut.state_q), 32'(DBUSY));
    check("r_streak1", 32'(dut.streak_q), 32'd1);
    rst = 1; ram_ready = 1; settle();
    check("r_dhit_in_rst", 32'(dmem_hit), 32'd0);
    cyc();
    check("r_state", 32'(dut.state_q), 32'(IDLE));
    check("r_ren", 32'(ram_REN), 32'd0);
    check("r_wen", 32'(ram_WEN), 32'd0);
    check("r_addr", ram_addr, 32'd0);
    check("r_store", ram_store, 32'd0);
    check("r_dhit", 32'(dmem_hit), 32'd0);
    check("r_ihit_idle_ready", 32'(imem_hit), 32'd0);
    check("r_streak", 32'(dut.streak_q), 32'd0);
    rst = 0; imemREN = 0; dmemREN = 0; ram_ready = 0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_imem_dmem_arbiter
`default_nettype wire

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-ported unified memory port between the fetch stage (instruction reads) and the scalar load/store path (data reads/writes).
- Sits between the fetch stage's imemREN/imemaddr/imemload signals, the scalar LSU, and the memory/cache controller.
- Serialises requests with a 3-state FSM: data has priority, plus a streak limiter so fetch cannot starve.
- Supports dropping an in-flight fetch on a misprediction redirect.

Parameters:
- WORD_W, 32, width of addresses and data (matches word_t).
- MAX_D_STREAK, 4, maximum consecutive data grants while fetch is waiting; after this many, fetch wins the next arbitration.
- STREAK_W, 3, width of the streak counter; must satisfy 2^STREAK_W > MAX_D_STREAK.

Ports:
- CLK  in  1  clock
- rst  in  1  synchronous reset, active-high
- imemREN  in  1  fetch read request, held until imem_hit
- imemaddr  in  WORD_W  fetch address
- iabort  in  1  fetch redirect (misprediction); drops the outstanding fetch response
- imem_hit  out  1  fetch data valid, single-cycle pulse
- imemload  out  WORD_W  fetch data
- dmemREN  in  1  data read request, held until dmem_hit
- dmemWEN  in  1  data write request, held until dmem_hit
- dmemaddr  in  WORD_W  data address
- dmemstore  in  WORD_W  write data
- dmem_hit  out  1  data transaction complete, single-cycle pulse
- dmemload  out  WORD_W  read data
- ram_REN  out  1  memory read strobe
- ram_WEN  out  1  memory write strobe
- ram_addr  out  WORD_W  memory address
- ram_store  out  WORD_W  memory write data
- ram_load  in  WORD_W  memory read data
- ram_ready  in  1  memory completes the current access this cycle

Behaviour:
- FSM states: IDLE, IBUSY, DBUSY.
- Reset values:
  - state = IDLE, streak = 0, drop = 0.
  - All ram_* outputs = 0.
  - imem_hit = dmem_hit = 0; imemload = dmemload = 0.
- IDLE arbitration (registered; the memory access starts the next cycle):
  - Only imemREN → IBUSY.
  - Only dmemREN/dmemWEN → DBUSY.
  - Both pending → DBUSY if streak < MAX_D_STREAK, else IBUSY.
  - Neither → stay in IDLE.
  - iabort together with imemREN in IDLE → that fetch is not granted this cycle.
- Granting latches the request into internal registers:
  - Latched: address, write data, and read/write type.
  - Requester changes during the busy state are ignored.
- Streak counter:
  - Increments on a data grant while imemREN = 1.
  - Clears on a fetch grant, or in IDLE when imemREN = 0.
  - Saturates at MAX_D_STREAK.
- IBUSY:
  - ram_REN = 1; ram_addr = latched fetch address.
  - On ram_ready: imem_hit = !(drop | iabort), imemload = ram_load (combinational from ram_load), then → IDLE.
- DBUSY:
  - dmemWEN has priority if both dmemWEN and dmemREN are set; in that case ram_WEN = 1, ram_REN = 0, and ram_store = latched data.
  - Otherwise ram_REN = 1.
  - On ram_ready: dmem_hit = 1; for a read, dmemload = ram_load; then → IDLE.
- Abort:
  - iabort during IBUSY sets drop.
  - The memory access still completes; the response is suppressed.
  - drop clears on exit from IBUSY.
- Hit outputs:
  - Hits are never asserted outside the cycle ram_ready is high in the matching state.
  - ram_ready in IDLE is ignored.
- Back-to-back access:
  - Minimum 2 cycles per access (grant cycle plus access cycle).
  - A requester holding its request after a hit is arbitrated again in IDLE.
- rst mid-access:
  - → IDLE; all strobes drop the next cycle.
  - No hit is produced for the abandoned access.

Decomposition:
- isa_pkg (shared): word_t; arbiter state enum arb_state_t {IDLE, IBUSY, DBUSY}.
- Local request record (addr, store, wen) as a packed struct in the same package.
- Single module; no sub-module needed.

Test Plan:
- Fetch-only request:
  - Stimulus: imemREN = 1, addr 0x100; ram_ready high 2 cycles after the grant, ram_load 0xDEADBEEF.
  - Required: one imem_hit pulse with imemload = 0xDEADBEEF; ram_REN high for 3 cycles; no dmem_hit.
- Simultaneous request:
  - Stimulus: imemREN and dmemREN both held; ram_ready every access cycle.
  - Required: data is served 4 times consecutively, then fetch is served once; pattern D,D,D,D,I repeats.
- Write priority:
  - Stimulus: dmemWEN = dmemREN = 1, addr 0x40, store 0x1234.
  - Required: ram_WEN = 1, ram_REN = 0, ram_store = 0x1234; dmem_hit after ram_ready.
- Abort:
  - Stimulus: iabort pulsed during IBUSY, before ram_ready.
  - Required: access completes with no imem_hit; the next fetch to 0x200 returns normally.
- Address stability:
  - Stimulus: change imemaddr during IBUSY.
  - Required: ram_addr keeps the latched address.
- Reset mid-DBUSY:
  - Stimulus: assert rst during DBUSY.
  - Required: next cycle state = IDLE, all ram_* = 0, no dmem_hit, streak = 0.
